// File: rtl/add32_rr_sched_pkg.sv
// rtl/add32_rr_sched_pkg.sv - shared types, defaults and arbitration helper
// Purpose: default operand width, FSM state encoding and the round-robin
//          pick function shared by the scheduler and its interface.
// Ports:   none (package).
package add32_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // First set bit of valid, searching upward from ptr and wrapping modulo nreq.
  // Up to 8 requesters; the caller checks that at least one valid bit is set.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int nreq);
    logic [2:0] pick;
    logic [2:0] sel;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = (int'(ptr) + k) % nreq;
      sel = 3'(idx);
      if (k < nreq && !found && valid[sel]) begin
        pick  = sel;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/add32_rr_sched_if.sv
// rtl/add32_rr_sched_if.sv - requester and response bundle for the adder scheduler
// Purpose: groups the per-requester request handshake and the tagged response.
// Ports:   req_valid/req_ready/req_a/req_b/req_cin (NREQ requesters, packed),
//          rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_cout (single response port).
//          master = requester/consumer side, slave = scheduler side.
interface add32_rr_sched_if
  import add32_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/add32_reg_core.sv
// rtl/add32_reg_core.sv - shared registered adder datapath
// Purpose: captures {cout, sum} = a + b + cin when load is high.
// Ports:   clock, reset (async, active-high), load, a, b, cin -> sum, cout.
module add32_reg_core
  import add32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Operands are widened first so the carry comes from a full WIDTH+1 add.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (load) begin
      {cout, sum} <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end
  end

endmodule

// File: rtl/add32_rr_sched.sv
// rtl/add32_rr_sched.sv - round-robin scheduler sharing one registered adder
// Purpose: grants one requester at a time, runs its operands through the
//          shared adder and returns the tagged result.
// Ports:   clock, reset (async, active-high), bus (slave side of
//          add32_rr_sched_if), busy (state != IDLE), op_count (completed
//          responses, wraps).
module add32_rr_sched
  import add32_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
) (
  input  logic            clock,
  input  logic            reset,
  add32_rr_sched_if.slave bus,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [IDW-1:0]   g_q;
  logic [IDW-1:0]   ptr;
  logic             rsp_valid_q;
  logic             any_valid;
  logic [IDW-1:0]   grant;
  logic             load;

  assign any_valid = |bus.req_valid;
  assign grant     = IDW'(rr_pick(8'(bus.req_valid), 3'(ptr), NREQ));
  assign load      = (state == EXEC);

  // Grant is a pure decode of the IDLE state; reset forces it low so nothing
  // looks accepted while the block is being cleared.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && any_valid && !reset) begin
      bus.req_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      g_q         <= '0;
      ptr         <= '0;
      rsp_valid_q <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            a_q   <= bus.req_a[grant*WIDTH +: WIDTH];
            b_q   <= bus.req_b[grant*WIDTH +: WIDTH];
            cin_q <= bus.req_cin[grant];
            g_q   <= grant;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count    <= op_count + 1'b1;
            // Next search starts just past the requester that was served.
            ptr         <= (g_q == IDW'(NREQ - 1)) ? '0 : g_q + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  add32_reg_core #(.WIDTH(WIDTH)) u_core (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .a     (a_q),
    .b     (b_q),
    .cin   (cin_q),
    .sum   (bus.rsp_sum),
    .cout  (bus.rsp_cout)
  );

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = g_q;
  assign busy          = (state != IDLE);

endmodule
